// File: rtl/fma16_stim_gen.sv
// fma16_stim_gen: LFSR-based operand/control vector source for the fma16 datapath.
// Issues a bounded, reproducible stream of vectors over a valid/ready handshake.
`default_nettype none

module fma16_stim_gen #(
   parameter logic [15:0] SEED_X = 16'hACE1,
   parameter logic [15:0] SEED_Y = 16'h1234,
   parameter logic [15:0] SEED_Z = 16'hBEEF,
   parameter int          CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] num_vec,
   input  logic             ctrl_rand,
   input  logic             cfg_mul,
   input  logic             cfg_add,
   input  logic             cfg_negr,
   input  logic             cfg_negz,
   input  logic [1:0]       cfg_roundmode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      x,
   output logic [15:0]      y,
   output logic [15:0]      z,
   output logic             mul,
   output logic             add,
   output logic             negr,
   output logic             negz,
   output logic [1:0]       roundmode,
   output logic [CNT_W-1:0] vec_idx,
   output logic             busy,
   output logic             done
);

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [15:0] c_SEED_X = (SEED_X == 16'h0000) ? 16'h0001 : SEED_X;
   localparam logic [15:0] c_SEED_Y = (SEED_Y == 16'h0000) ? 16'h0001 : SEED_Y;
   localparam logic [15:0] c_SEED_Z = (SEED_Z == 16'h0000) ? 16'h0001 : SEED_Z;
   localparam logic [15:0] c_TAPS   = 16'hB400;
   localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      lx_q, lx_d;
   logic [15:0]      ly_q, ly_d;
   logic [15:0]      lz_q, lz_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rand_q, rand_d;
   logic [5:0]       cfg_q, cfg_d;

   logic [5:0]       w_rand_ctrl;
   logic [5:0]       w_ctrl;
   logic             w_show;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? c_TAPS : 16'h0000);
   endfunction

   always_comb begin
      state_d = state_q;
      lx_d    = lx_q;
      ly_d    = ly_q;
      lz_d    = lz_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      rand_d  = rand_q;
      cfg_d   = cfg_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               cnt_d   = num_vec;
               rand_d  = ctrl_rand;
               cfg_d   = {cfg_roundmode, cfg_negz, cfg_negr, cfg_add, cfg_mul};
               lx_d    = c_SEED_X;
               ly_d    = c_SEED_Y;
               lz_d    = c_SEED_Z;
               idx_d   = '0;
               state_d = (num_vec == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (out_ready) begin
               lx_d = lfsr_step(lx_q);
               ly_d = lfsr_step(ly_q);
               lz_d = lfsr_step(lz_q);
               // The index stops on the last vector so DONE reports count-1.
               if (idx_q == cnt_q - c_ONE) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q + c_ONE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         lx_q    <= c_SEED_X;
         ly_q    <= c_SEED_Y;
         lz_q    <= c_SEED_Z;
         idx_q   <= '0;
         cnt_q   <= '0;
         rand_q  <= 1'b0;
         cfg_q   <= '0;
      end else begin
         state_q <= state_d;
         lx_q    <= lx_d;
         ly_q    <= ly_d;
         lz_q    <= lz_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         rand_q  <= rand_d;
         cfg_q   <= cfg_d;
      end
   end

   // Data outputs read zero until the first run so reset presents a clean bus.
   assign w_show      = (state_q != ST_IDLE);
   assign w_rand_ctrl = lz_q[5:0] ^ ly_q[15:10];
   assign w_ctrl      = rand_q ? w_rand_ctrl : cfg_q;

   assign x         = w_show ? lx_q : 16'h0000;
   assign y         = w_show ? ly_q : 16'h0000;
   assign z         = w_show ? lz_q : 16'h0000;
   assign mul       = w_show & w_ctrl[0];
   assign add       = w_show & w_ctrl[1];
   assign negr      = w_show & w_ctrl[2];
   assign negz      = w_show & w_ctrl[3];
   assign roundmode = w_show ? w_ctrl[5:4] : 2'b00;

   assign out_valid = (state_q == ST_RUN);
   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign vec_idx   = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_fma16_stim_gen.sv
// tb_fma16_stim_gen: directed self-checking bench for fma16_stim_gen.
`default_nettype none

module tb_fma16_stim_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] num_vec;
   logic        ctrl_rand;
   logic        cfg_mul, cfg_add, cfg_negr, cfg_negz;
   logic [1:0]  cfg_roundmode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] x, y, z;
   logic        mul, add, negr, negz;
   logic [1:0]  roundmode;
   logic [15:0] vec_idx;
   logic        busy, done;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   fma16_stim_gen #(
      .SEED_X(16'hACE1), .SEED_Y(16'h1234), .SEED_Z(16'hBEEF), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .num_vec(num_vec),
      .ctrl_rand(ctrl_rand), .cfg_mul(cfg_mul), .cfg_add(cfg_add),
      .cfg_negr(cfg_negr), .cfg_negz(cfg_negz), .cfg_roundmode(cfg_roundmode),
      .out_valid(out_valid), .out_ready(out_ready),
      .x(x), .y(y), .z(z), .mul(mul), .add(add), .negr(negr), .negz(negz),
      .roundmode(roundmode), .vec_idx(vec_idx), .busy(busy), .done(done)
   );

   function automatic logic [15:0] ref_step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Called at posedge+1; returns at posedge+1 of the cycle the first vector shows.
   task automatic do_start(input logic [15:0] n, input logic r, input logic [5:0] cfg);
      num_vec       = n;
      ctrl_rand     = r;
      {cfg_roundmode, cfg_negz, cfg_negr, cfg_add, cfg_mul} = cfg;
      start         = 1'b1;
      @(posedge clk); #1;
      start         = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; out_ready = 1'b0; num_vec = '0; ctrl_rand = 1'b0;
      {cfg_roundmode, cfg_negz, cfg_negr, cfg_add, cfg_mul} = 6'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({out_valid, busy, done} !== 3'b000) begin
         tests_failed++; $display("FAIL reset_flags got %b want 000", {out_valid, busy, done});
      end
      tests_run++;
      if ({x, y, z, vec_idx} !== 64'h0) begin
         tests_failed++; $display("FAIL reset_data got %h %h %h idx %h want all 0", x, y, z, vec_idx);
      end
      tests_run++;
      if ({mul, add, negr, negz, roundmode} !== 6'b0) begin
         tests_failed++; $display("FAIL reset_ctrl got %b want 000000", {mul, add, negr, negz, roundmode});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_random_run();
      out_ready = 1'b1;
      do_start(16'd3, 1'b1, 6'b0);
      tests_run++;
      if ({out_valid, x, y, z, vec_idx} !== {1'b1, 16'hACE1, 16'h1234, 16'hBEEF, 16'd0}) begin
         tests_failed++;
         $display("FAIL vec0_data got v=%b %h %h %h idx %0d want 1 ACE1 1234 BEEF 0", out_valid, x, y, z, vec_idx);
      end
      tests_run++;
      if ({mul, add, negr, negz, roundmode} !== {4'b1101, 2'b10}) begin
         tests_failed++; $display("FAIL vec0_ctrl got %b want 110110", {mul, add, negr, negz, roundmode});
      end
      tick();
      tests_run++;
      if ({x, y, z, vec_idx} !== {16'hE270, 16'h091A, 16'hEB77, 16'd1}) begin
         tests_failed++; $display("FAIL vec1_data got %h %h %h idx %0d want E270 091A EB77 1", x, y, z, vec_idx);
      end
      tests_run++;
      if ({mul, add, negr, negz, roundmode} !== {4'b1010, 2'b11}) begin
         tests_failed++; $display("FAIL vec1_ctrl got %b want 101011", {mul, add, negr, negz, roundmode});
      end
      tick();
      tests_run++;
      if ({out_valid, x, vec_idx} !== {1'b1, 16'h7138, 16'd2}) begin
         tests_failed++; $display("FAIL vec2 got v=%b x=%h idx %0d want 1 7138 2", out_valid, x, vec_idx);
      end
      tick();
      tests_run++;
      if ({out_valid, busy, done, vec_idx, x} !== {3'b001, 16'd2, 16'h389C}) begin
         tests_failed++;
         $display("FAIL run3_done got v/b/d=%b idx %0d x=%h want 001 2 389C", {out_valid, busy, done}, vec_idx, x);
      end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      out_ready = 1'b0;
      do_start(16'd3, 1'b1, 6'b0);
      for (int i = 0; i < 5; i++) begin
         if ({out_valid, x, y, z, vec_idx} !== {1'b1, 16'hACE1, 16'h1234, 16'hBEEF, 16'd0}) bad++;
         tick();
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tests_run++;
      if ({x, vec_idx} !== {16'hE270, 16'd1}) begin
         tests_failed++; $display("FAIL bp_advance got x=%h idx %0d want E270 1", x, vec_idx);
      end
      tick();
      tests_run++;
      if ({out_valid, x, vec_idx} !== {1'b1, 16'hE270, 16'd1}) begin
         tests_failed++; $display("FAIL bp_once got v=%b x=%h idx %0d want 1 E270 1", out_valid, x, vec_idx);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 10 && !done; i++) tick();
      tests_run++;
      if (done !== 1'b1) begin
         tests_failed++; $display("FAIL bp_drain got done=%b want 1 (timeout)", done);
      end
   endtask

   task automatic test_zero_count();
      int seen = 0;
      out_ready = 1'b1;
      do_start(16'd0, 1'b1, 6'b0);
      tests_run++;
      if ({out_valid, done} !== 2'b01) begin
         tests_failed++; $display("FAIL zero_done got v/d=%b want 01", {out_valid, done});
      end
      for (int i = 0; i < 4; i++) begin
         if (out_valid !== 1'b0) seen++;
         tick();
      end
      tests_run++;
      if (seen != 0 || done !== 1'b1) begin
         tests_failed++; $display("FAIL zero_quiet got valid_cycles=%0d done=%b want 0 1", seen, done);
      end
   endtask

   task automatic test_fixed_ctrl();
      logic [15:0] mx = 16'hACE1, my = 16'h1234, mz = 16'hBEEF;
      out_ready = 1'b1;
      // cfg packing {rm, negz, negr, add, mul} = 01,1,0,0,0
      do_start(16'd4, 1'b0, 6'b011000);
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if ({out_valid, mul, add, negr, negz, roundmode, x, y, z} !==
             {1'b1, 4'b0001, 2'b01, mx, my, mz}) begin
            tests_failed++;
            $display("FAIL fixed_vec%0d got v=%b ctl=%b %h %h %h want 1 000101 %h %h %h",
                     i, out_valid, {mul, add, negr, negz, roundmode}, x, y, z, mx, my, mz);
         end
         mx = ref_step(mx); my = ref_step(my); mz = ref_step(mz);
         tick();
      end
      tests_run++;
      if (done !== 1'b1) begin
         tests_failed++; $display("FAIL fixed_done got %b want 1", done);
      end
   endtask

   task automatic test_reset_mid_run();
      out_ready = 1'b1;
      do_start(16'd5, 1'b1, 6'b0);
      tick();
      tick();
      tests_run++;
      if ({out_valid, vec_idx} !== {1'b1, 16'd2}) begin
         tests_failed++; $display("FAIL mid_pre got v=%b idx %0d want 1 2", out_valid, vec_idx);
      end
      reset = 1'b1;
      #1;
      tests_run++;
      if ({out_valid, busy, done, vec_idx} !== {3'b000, 16'd0}) begin
         tests_failed++;
         $display("FAIL mid_reset got v/b/d=%b idx %0d want 000 0", {out_valid, busy, done}, vec_idx);
      end
      tick();
      reset = 1'b0;
      tick();
      tests_run++;
      if ({out_valid, busy, done} !== 3'b000) begin
         tests_failed++; $display("FAIL mid_idle got v/b/d=%b want 000", {out_valid, busy, done});
      end
      do_start(16'd2, 1'b1, 6'b0);
      tests_run++;
      if ({out_valid, x, vec_idx} !== {1'b1, 16'hACE1, 16'd0}) begin
         tests_failed++; $display("FAIL mid_replay got v=%b x=%h idx %0d want 1 ACE1 0", out_valid, x, vec_idx);
      end
      for (int i = 0; i < 5 && !done; i++) tick();
   endtask

   task automatic test_back_to_back_long();
      logic [15:0] mx = 16'hACE1, my = 16'h1234, mz = 16'hBEEF;
      logic [5:0]  mc;
      int          nxfer = 0;
      int          idx_bad = 0;
      logic [53:0] last_got = '0;
      out_ready = 1'b1;
      do_start(16'd1000, 1'b1, 6'b0);
      for (int cyc = 0; cyc < 1100 && !done; cyc++) begin
         if (out_valid === 1'b1) begin
            if (vec_idx !== nxfer[15:0]) idx_bad++;
            if (nxfer == 999) begin
               mc = mz[5:0] ^ my[15:10];
               last_got = {x, y, z, roundmode, negz, negr, add, mul};
               tests_run++;
               if (last_got !== {mx, my, mz, mc}) begin
                  tests_failed++;
                  $display("FAIL long_vec999 got %h want %h", last_got, {mx, my, mz, mc});
               end
            end
            nxfer++;
            mx = ref_step(mx); my = ref_step(my); mz = ref_step(mz);
         end
         tick();
      end
      tests_run++;
      if (done !== 1'b1 || nxfer != 1000 || idx_bad != 0) begin
         tests_failed++;
         $display("FAIL long_count got done=%b xfers=%0d idx_errs=%0d want 1 1000 0", done, nxfer, idx_bad);
      end
      tests_run++;
      if (vec_idx !== 16'd999) begin
         tests_failed++; $display("FAIL long_idx got %0d want 999", vec_idx);
      end
      do_start(16'd2, 1'b1, 6'b0);
      tests_run++;
      if ({out_valid, x, y, z, vec_idx} !== {1'b1, 16'hACE1, 16'h1234, 16'hBEEF, 16'd0}) begin
         tests_failed++;
         $display("FAIL restart got v=%b %h %h %h idx %0d want 1 ACE1 1234 BEEF 0", out_valid, x, y, z, vec_idx);
      end
   endtask

   initial begin
      test_reset();
      test_random_run();
      test_backpressure();
      test_zero_count();
      test_fixed_ctrl();
      test_reset_mid_run();
      test_back_to_back_long();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
